// File: rtl/ddr_serializer_tx.sv
// rtl/ddr_serializer_tx.sv - parallel-to-DDR bit-pair serializer with one-word holding buffer
module ddr_serializer_tx #(
  parameter int   DATA_WIDTH = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  D1,
  output logic                  D2,
  output logic                  FRAME,
  output logic                  BUSY
);

  localparam int NPAIRS = DATA_WIDTH / 2;
  localparam int CW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(NPAIRS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [DATA_WIDTH-1:0]   shift_data;
  logic                    hold_full;
  logic [CW-1:0]           pair_cnt;

  logic                    accept;
  logic                    last_pair;
  logic                    load;
  logic                    hold_full_next;
  logic [DATA_WIDTH-1:0]   load_word;

  // The buffer always feeds the shifter first so words leave in arrival order.
  always_comb begin
    accept         = DATA_VALID && DATA_READY;
    last_pair      = (state == SHIFT) && (pair_cnt == LAST_PAIR);
    load           = ((state == IDLE) || last_pair) && ENABLE && (hold_full || accept);
    load_word      = hold_full ? hold_data : DATA_IN;
    hold_full_next = hold_full;
    if (load && hold_full)
      hold_full_next = accept;
    else if (!load && accept)
      hold_full_next = 1'b1;
  end

  assign BUSY = (state == SHIFT) || hold_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      hold_data  <= '0;
      shift_data <= '0;
      hold_full  <= 1'b0;
      pair_cnt   <= '0;
      DATA_READY <= 1'b0;
      D1         <= IDLE_LEVEL;
      D2         <= IDLE_LEVEL;
      FRAME      <= 1'b0;
    end else begin
      hold_full  <= hold_full_next;
      DATA_READY <= !hold_full_next;
      if (accept && hold_full_next)
        hold_data <= DATA_IN;

      if (load) begin
        state      <= SHIFT;
        pair_cnt   <= '0;
        D1         <= load_word[DATA_WIDTH-1];
        D2         <= load_word[DATA_WIDTH-2];
        FRAME      <= 1'b1;
        shift_data <= load_word << 2;
      end else if ((state == SHIFT) && !last_pair) begin
        pair_cnt   <= pair_cnt + 1'b1;
        D1         <= shift_data[DATA_WIDTH-1];
        D2         <= shift_data[DATA_WIDTH-2];
        FRAME      <= 1'b0;
        shift_data <= shift_data << 2;
      end else begin
        state    <= IDLE;
        pair_cnt <= '0;
        D1       <= IDLE_LEVEL;
        D2       <= IDLE_LEVEL;
        FRAME    <= 1'b0;
      end
    end
  end

endmodule
